// File: rtl/processing_unit_param.sv
// rtl/processing_unit_param.sv - parameterised datapath: register file, PC, IR, address, Y/Z, ALU
// Optional feature macro: PROCESSING_UNIT_CARRY_EN (adds cflag register and ADC opcode 5).
module processing_unit_param #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 8,
  parameter int OP_SIZE   = 4,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] mem_word,
  input  logic                 mem_valid,
  input  logic                 reg_wr_en,
  input  logic [SEL_W-1:0]     reg_wr_sel,
  input  logic [SEL_W-1:0]     reg_rd_sel,
  input  logic                 bus1_sel_pc,
  input  logic [1:0]           bus2_sel,
  input  logic                 load_pc,
  input  logic                 inc_pc,
  input  logic                 load_ir,
  input  logic                 load_addr,
  input  logic                 load_y,
  input  logic                 load_z,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] bus_1,
  output logic                 zflag,
  output logic                 cflag,
  output logic                 stall
);

  localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_NOT = OP_SIZE'(4);

  localparam logic [1:0] B2_ALU  = 2'b00;
  localparam logic [1:0] B2_BUS1 = 2'b01;
  localparam logic [1:0] B2_MEM  = 2'b10;

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] ir_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] y_q;
  logic                 zflag_q;

  logic [WORD_SIZE-1:0] bus_2;
  logic [WORD_SIZE-1:0] alu_result;
  logic [OP_SIZE-1:0]   opcode;
  logic                 any_bus2_load;

  assign opcode      = ir_q[WORD_SIZE-1 -: OP_SIZE];
  assign instruction = ir_q;
  assign address     = addr_q;
  assign zflag       = zflag_q;

  // Bus_1 source: PC or the selected general register (pre-edge value, so a
  // same-cycle write is only seen on the following cycle).
  assign bus_1 = bus1_sel_pc ? pc_q : regs[reg_rd_sel];

  // Any strobe that consumes Bus_2 must wait if Bus_2 is sourced from memory
  // and the memory word is not yet valid; load_z and inc_pc do not use Bus_2
  // but are frozen along with everything else.
  assign any_bus2_load = reg_wr_en | load_pc | load_ir | load_addr | load_y;
  assign stall         = (bus2_sel == B2_MEM) && !mem_valid && any_bus2_load;

  // Bus_2 source multiplexer.
  always_comb begin
    bus_2 = '0;
    case (bus2_sel)
      B2_ALU:  bus_2 = alu_result;
      B2_BUS1: bus_2 = bus_1;
      B2_MEM:  bus_2 = mem_word;
      default: bus_2 = '0;
    endcase
  end

`ifdef PROCESSING_UNIT_CARRY_EN
  localparam logic [OP_SIZE-1:0] OP_ADC = OP_SIZE'(5);

  logic                 cflag_q;
  logic [WORD_SIZE:0]   alu_wide;
  logic                 alu_carry;

  // ALU with one extra bit: carry-out for ADD/ADC, borrow for SUB, zero otherwise.
  always_comb begin
    alu_wide = '0;
    case (opcode)
      OP_ADD:  alu_wide = {1'b0, y_q} + {1'b0, bus_1};
      OP_SUB:  alu_wide = {1'b0, bus_1} - {1'b0, y_q};
      OP_AND:  alu_wide = {1'b0, y_q & bus_1};
      OP_NOT:  alu_wide = {1'b0, ~bus_1};
      OP_ADC:  alu_wide = {1'b0, y_q} + {1'b0, bus_1} + {{WORD_SIZE{1'b0}}, cflag_q};
      default: alu_wide = '0;
    endcase
  end

  assign alu_result = alu_wide[WORD_SIZE-1:0];
  assign alu_carry  = alu_wide[WORD_SIZE];
  assign cflag      = cflag_q;

  // Carry flag captured alongside the zero flag on load_z.
  always_ff @(posedge clk) begin
    if (rst) begin
      cflag_q <= 1'b0;
    end else if (load_z && !stall) begin
      cflag_q <= alu_carry;
    end
  end
`else
  // ALU without carry: results wrap modulo 2^WORD_SIZE.
  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_ADD:  alu_result = y_q + bus_1;
      OP_SUB:  alu_result = bus_1 - y_q;
      OP_AND:  alu_result = y_q & bus_1;
      OP_NOT:  alu_result = ~bus_1;
      default: alu_result = '0;
    endcase
  end

  assign cflag = 1'b0;
`endif

  // General register file: one write port from Bus_2.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_wr_en && !stall) begin
      regs[reg_wr_sel] <= bus_2;
    end
  end

  // Program counter: load beats increment; all-ones wraps to zero naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (!stall) begin
      if (load_pc) begin
        pc_q <= bus_2;
      end else if (inc_pc) begin
        pc_q <= pc_q + 1'b1;
      end
    end
  end

  // IR, address and Y registers all load the same Bus_2 value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q   <= '0;
      addr_q <= '0;
      y_q    <= '0;
    end else if (!stall) begin
      if (load_ir)   ir_q   <= bus_2;
      if (load_addr) addr_q <= bus_2;
      if (load_y)    y_q    <= bus_2;
    end
  end

  // Zero flag reflects the ALU result at the load_z edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      zflag_q <= 1'b0;
    end else if (load_z && !stall) begin
      zflag_q <= (alu_result == '0);
    end
  end

endmodule

// File: tb/tb_processing_unit_param.sv
// tb/tb_processing_unit_param.sv - randomized self-checking bench for processing_unit_param
`timescale 1ns/1ps
module tb_processing_unit_param;

`ifdef PROCESSING_UNIT_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       rst;
  logic [7:0] mem_word;
  logic       mem_valid, reg_wr_en;
  logic [2:0] reg_wr_sel, reg_rd_sel;
  logic       bus1_sel_pc;
  logic [1:0] bus2_sel;
  logic       load_pc, inc_pc, load_ir, load_addr, load_y, load_z;
  logic [7:0] instruction, address, bus_1;
  logic       zflag, cflag, stall;

  processing_unit_param dut (
    .clk(clk), .rst(rst), .mem_word(mem_word), .mem_valid(mem_valid),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_rd_sel(reg_rd_sel),
    .bus1_sel_pc(bus1_sel_pc), .bus2_sel(bus2_sel), .load_pc(load_pc), .inc_pc(inc_pc),
    .load_ir(load_ir), .load_addr(load_addr), .load_y(load_y), .load_z(load_z),
    .instruction(instruction), .address(address), .bus_1(bus_1),
    .zflag(zflag), .cflag(cflag), .stall(stall)
  );

  // wide instance: 16 registers of 16 bits
  logic        w_rst;
  logic [15:0] w_mem_word;
  logic        w_mem_valid, w_reg_wr_en;
  logic [3:0]  w_reg_wr_sel, w_reg_rd_sel;
  logic        w_bus1_sel_pc;
  logic [1:0]  w_bus2_sel;
  logic        w_load_pc, w_inc_pc, w_load_ir, w_load_addr, w_load_y, w_load_z;
  logic [15:0] w_instruction, w_address, w_bus_1;
  logic        w_zflag, w_cflag, w_stall;

  processing_unit_param #(.WORD_SIZE(16), .NUM_REGS(16), .OP_SIZE(4)) dut_wide (
    .clk(clk), .rst(w_rst), .mem_word(w_mem_word), .mem_valid(w_mem_valid),
    .reg_wr_en(w_reg_wr_en), .reg_wr_sel(w_reg_wr_sel), .reg_rd_sel(w_reg_rd_sel),
    .bus1_sel_pc(w_bus1_sel_pc), .bus2_sel(w_bus2_sel), .load_pc(w_load_pc), .inc_pc(w_inc_pc),
    .load_ir(w_load_ir), .load_addr(w_load_addr), .load_y(w_load_y), .load_z(w_load_z),
    .instruction(w_instruction), .address(w_address), .bus_1(w_bus_1),
    .zflag(w_zflag), .cflag(w_cflag), .stall(w_stall)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state (plain integers, arithmetic modulo 256)
  int unsigned m_regs [8];
  int unsigned m_pc, m_ir, m_addr, m_y;
  bit          m_z, m_c;

  function automatic int unsigned exp_bus1();
    return bus1_sel_pc ? m_pc : m_regs[reg_rd_sel];
  endfunction

  function automatic bit exp_stall();
    return (bus2_sel == 2'd2) && !mem_valid &&
           (reg_wr_en || load_pc || load_ir || load_addr || load_y);
  endfunction

  task automatic model_alu(input int unsigned b1, output int unsigned r, output bit c);
    int unsigned s;
    r = 0;
    c = 0;
    case (m_ir / 16)
      1: begin s = m_y + b1; r = s % 256; c = (s > 255); end
      2: begin r = (b1 + 256 - m_y) % 256; c = (b1 < m_y); end
      3: r = m_y & b1;
      4: r = 255 - b1;
      5: if (CARRY_ON) begin s = m_y + b1 + 32'(m_c); r = s % 256; c = (s > 255); end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    int unsigned b1, b2, r;
    bit c;
    b1 = exp_bus1();
    model_alu(b1, r, c);
    case (bus2_sel)
      2'd0: b2 = r;
      2'd1: b2 = b1;
      2'd2: b2 = 32'(mem_word);
      default: b2 = 0;
    endcase
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_pc = 0; m_ir = 0; m_addr = 0; m_y = 0; m_z = 0; m_c = 0;
    end else if (!exp_stall()) begin
      if (reg_wr_en) m_regs[reg_wr_sel] = b2;
      if (load_pc) m_pc = b2;
      else if (inc_pc) m_pc = (m_pc + 1) % 256;
      if (load_ir) m_ir = b2;
      if (load_addr) m_addr = b2;
      if (load_y) m_y = b2;
      if (load_z) begin
        m_z = (r == 0);
        m_c = CARRY_ON ? c : 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; mem_word = 8'h00; mem_valid = 1; reg_wr_en = 0; reg_wr_sel = 0; reg_rd_sel = 0;
    bus1_sel_pc = 0; bus2_sel = 2'd0; load_pc = 0; inc_pc = 0; load_ir = 0;
    load_addr = 0; load_y = 0; load_z = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; load_ir = 1; bus2_sel = 2'd2; mem_valid = 0;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_stall: got %b expected 1", stall);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (instruction !== 8'h00 || address !== 8'h00 || zflag !== 1'b0 || cflag !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: ir=%h addr=%h z=%b c=%b expected all 0", instruction, address, zflag, cflag);
    end
    for (int i = 0; i < 9; i++) begin
      bus1_sel_pc = (i == 8);
      reg_rd_sel = 3'(i % 8);
      #1;
      tests_run++;
      if (bus_1 !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_bus1_%0d: got %h expected 00", i, bus_1);
      end
    end
  endtask

  task automatic test_pc();
    idle();
    bus1_sel_pc = 1; inc_pc = 1;
    repeat (3) tick();
    inc_pc = 0;
    #1;
    tests_run++;
    if (bus_1 !== 8'h03) begin
      tests_failed++;
      $display("FAIL pc_inc3: got %h expected 03", bus_1);
    end
    bus2_sel = 2'd2; mem_word = 8'hFF; load_pc = 1;
    tick();
    load_pc = 0; inc_pc = 1;
    tick();
    inc_pc = 0;
    #1;
    tests_run++;
    if (bus_1 !== 8'h00) begin
      tests_failed++;
      $display("FAIL pc_wrap: got %h expected 00", bus_1);
    end
    mem_word = 8'h40; load_pc = 1; inc_pc = 1;
    tick();
    load_pc = 0; inc_pc = 0;
    #1;
    tests_run++;
    if (bus_1 !== 8'h40) begin
      tests_failed++;
      $display("FAIL pc_load_wins: got %h expected 40", bus_1);
    end
  endtask

  task automatic test_alu_zero();
    idle();
    bus2_sel = 2'd2; mem_word = 8'h0F; reg_wr_en = 1; reg_wr_sel = 3'd2;
    reg_rd_sel = 3'd2;
    #1;
    tests_run++;
    if (bus_1 !== 8'h00) begin
      tests_failed++;
      $display("FAIL same_cycle_read: got %h expected 00", bus_1);
    end
    tick();
    reg_wr_en = 0;
    #1;
    tests_run++;
    if (bus_1 !== 8'h0F) begin
      tests_failed++;
      $display("FAIL r2_written: got %h expected 0F", bus_1);
    end
    mem_word = 8'hF1; load_y = 1;
    tick();
    load_y = 0; mem_word = 8'h10; load_ir = 1;
    tick();
    load_ir = 0; bus2_sel = 2'd0; load_z = 1; load_addr = 1;
    tick();
    load_z = 0; load_addr = 0;
    #1;
    tests_run++;
    if (instruction !== 8'h10 || address !== 8'h00 || zflag !== 1'b1 || cflag !== CARRY_ON) begin
      tests_failed++;
      $display("FAIL add_zero: ir=%h addr=%h z=%b c=%b expected ir=10 addr=00 z=1 c=%b",
               instruction, address, zflag, cflag, CARRY_ON);
    end
  endtask

  task automatic test_stall();
    idle();
    bus1_sel_pc = 1; bus2_sel = 2'd2; load_ir = 1; mem_valid = 0; inc_pc = 1; load_z = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_asserted_%0d: got %b expected 1", i, stall);
      end
      tick();
      tests_run++;
      if (bus_1 !== 8'h40 || instruction !== 8'h10 || zflag !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: pc=%h ir=%h z=%b expected pc=40 ir=10 z=1", i, bus_1, instruction, zflag);
      end
    end
    mem_valid = 1; mem_word = 8'h2A;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: got %b expected 0", stall);
    end
    tick();
    idle();
    bus1_sel_pc = 1;
    #1;
    tests_run++;
    if (instruction !== 8'h2A || bus_1 !== 8'h41 || zflag !== m_z || cflag !== m_c) begin
      tests_failed++;
      $display("FAIL stall_done: ir=%h pc=%h z=%b c=%b expected ir=2A pc=41 z=%b c=%b",
               instruction, bus_1, zflag, cflag, m_z, m_c);
    end
  endtask

  task automatic test_rst_mid_stall();
    idle();
    bus2_sel = 2'd2; mem_word = 8'h77; load_addr = 1; load_y = 1;
    tick();
    tests_run++;
    if (address !== 8'h77) begin
      tests_failed++;
      $display("FAIL addr_load: got %h expected 77", address);
    end
    mem_valid = 0; reg_wr_en = 1; reg_wr_sel = 3'd5; load_ir = 1; inc_pc = 1;
    tick();
    rst = 1;
    tick();
    idle();
    #1;
    tests_run++;
    if (instruction !== 8'h00 || address !== 8'h00 || zflag !== 1'b0 || cflag !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_stall: ir=%h addr=%h z=%b c=%b expected all 0", instruction, address, zflag, cflag);
    end
    for (int i = 0; i < 9; i++) begin
      bus1_sel_pc = (i == 8);
      reg_rd_sel = 3'(i % 8);
      #1;
      tests_run++;
      if (bus_1 !== 8'h00) begin
        tests_failed++;
        $display("FAIL rst_mid_stall_bus1_%0d: got %h expected 00", i, bus_1);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      mem_word    = 8'($urandom);
      mem_valid   = ($urandom_range(0, 3) != 0);
      reg_wr_en   = ($urandom_range(0, 2) == 0);
      reg_wr_sel  = 3'($urandom_range(0, 7));
      reg_rd_sel  = 3'($urandom_range(0, 7));
      bus1_sel_pc = ($urandom_range(0, 3) == 0);
      bus2_sel    = 2'($urandom_range(0, 3));
      load_pc     = ($urandom_range(0, 7) == 0);
      inc_pc      = ($urandom_range(0, 2) == 0);
      load_ir     = ($urandom_range(0, 3) == 0);
      load_addr   = ($urandom_range(0, 3) == 0);
      load_y      = ($urandom_range(0, 2) == 0);
      load_z      = ($urandom_range(0, 1) == 0);
      #1;
      tests_run++;
      if (bus_1 !== 8'(exp_bus1()) || stall !== exp_stall()) begin
        tests_failed++;
        $display("FAIL rand_comb_%0d: bus_1=%h stall=%b expected bus_1=%h stall=%b",
                 n, bus_1, stall, 8'(exp_bus1()), exp_stall());
      end
      tick();
      tests_run++;
      if (instruction !== 8'(m_ir) || address !== 8'(m_addr) || zflag !== m_z || cflag !== m_c) begin
        tests_failed++;
        $display("FAIL rand_state_%0d: ir=%h addr=%h z=%b c=%b expected ir=%h addr=%h z=%b c=%b",
                 n, instruction, address, zflag, cflag, 8'(m_ir), 8'(m_addr), m_z, m_c);
      end
    end
    idle();
  endtask

  task automatic test_wide();
    w_rst = 1;
    tick();
    w_rst = 0; w_bus2_sel = 2'd2; w_mem_word = 16'hBEEF; w_mem_valid = 1;
    w_reg_wr_en = 1; w_reg_wr_sel = 4'd15; w_reg_rd_sel = 4'd15; w_bus1_sel_pc = 0;
    #1;
    tests_run++;
    if (w_bus_1 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wide_old_value: got %h expected 0000", w_bus_1);
    end
    tick();
    w_reg_wr_en = 0;
    #1;
    tests_run++;
    if (w_bus_1 !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL wide_new_value: got %h expected BEEF", w_bus_1);
    end
    w_mem_word = 16'hFFFF; w_load_pc = 1;
    tick();
    w_load_pc = 0; w_inc_pc = 1; w_bus1_sel_pc = 1;
    tick();
    w_inc_pc = 0;
    #1;
    tests_run++;
    if (w_bus_1 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wide_pc_wrap: got %h expected 0000", w_bus_1);
    end
  endtask

  initial begin
    idle();
    w_rst = 1; w_mem_word = '0; w_mem_valid = 1; w_reg_wr_en = 0; w_reg_wr_sel = '0;
    w_reg_rd_sel = '0; w_bus1_sel_pc = 0; w_bus2_sel = 2'd0; w_load_pc = 0; w_inc_pc = 0;
    w_load_ir = 0; w_load_addr = 0; w_load_y = 0; w_load_z = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_pc();
    test_alu_zero();
    test_stall();
    test_rst_mid_stall();
    test_random();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/processing_unit_param.md
PROCESSING_UNIT_PARAM -- requirements
Module: processing_unit_param

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 8, datapath and bus width in bits (min 4).
REQ-002 SHALL provide parameter NUM_REGS, default 8, general register count (power of 2, min 2); SEL_W = log2(NUM_REGS).
REQ-003 SHALL provide parameter OP_SIZE, default 4, opcode field width taken from instruction[WORD_SIZE-1 -: OP_SIZE].
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports follow.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mem_word  input  WORD_SIZE  memory read data.
REQ-008 mem_valid  input  1  mem_word valid this cycle.
REQ-009 reg_wr_en  input  1  write Bus_2 into register reg_wr_sel.
REQ-010 reg_wr_sel  input  SEL_W  destination register index.
REQ-011 reg_rd_sel  input  SEL_W  register driven onto Bus_1 when bus1_sel_pc=0.
REQ-012 bus1_sel_pc  input  1  1: Bus_1 = PC; 0: Bus_1 = reg[reg_rd_sel].
REQ-013 bus2_sel  input  2  00 ALU, 01 Bus_1, 10 mem_word, 11 all-zero.
REQ-014 load_pc, inc_pc, load_ir, load_addr, load_y, load_z  input  1 each  register load strobes.
REQ-015 instruction  output  WORD_SIZE  IR contents.
REQ-016 address  output  WORD_SIZE  address register contents.
REQ-017 bus_1  output  WORD_SIZE  current Bus_1 value.
REQ-018 zflag  output  1  registered ALU zero flag.
REQ-019 cflag  output  1  registered carry flag (see Configuration).
REQ-020 stall  output  1  combinational; memory-sourced load pending without valid data.

Function
REQ-021 Bus_1, Bus_2, ALU result SHALL be combinational; every register SHALL update on the rising clk edge after its strobe (latency 1 cycle).
REQ-022 ALU SHALL decode opcode: 1 ADD Y+Bus_1; 2 SUB Bus_1-Y; 3 AND Y&Bus_1; 4 NOT ~Bus_1; 5 ADC Y+Bus_1+cflag (macro only); all others result 0; results truncated to WORD_SIZE, wrapping modulo 2^WORD_SIZE.
REQ-023 load_z SHALL capture (ALU result == 0); with carry enabled, load_z SHALL also capture cflag = carry-out (ADD/ADC) or borrow (SUB), else 0.
REQ-024 PC: load_pc loads Bus_2; else inc_pc adds 1, wrapping all-ones to 0; load_pc SHALL win when both asserted.
REQ-025 stall SHALL be 1 when bus2_sel=10, mem_valid=0, and any of reg_wr_en, load_pc, load_ir, load_addr, load_y is 1.
REQ-026 While stall=1 every register and flag SHALL hold, inc_pc and load_z included; strobes SHALL be repeated by the controller until mem_valid=1.
REQ-027 Write and read of the same register in one cycle SHALL show the old value on bus_1; new value visible next cycle.
REQ-028 Multiple simultaneous strobes SHALL all load the same Bus_2 value in one edge.

Reset
REQ-029 rst=1 at a clock edge SHALL clear all general registers, PC, IR, address, Y, zflag, cflag to 0, overriding any strobe or stall.
REQ-030 After reset, bus_1 SHALL read 0 for every select; stall SHALL follow REQ-025 combinationally, including during reset.

Configuration
REQ-031 Macro PROCESSING_UNIT_CARRY_EN defined: cflag register and ADC opcode 5 SHALL be present.
REQ-032 Macro undefined: cflag SHALL be constant 0, opcode 5 result SHALL be 0, no carry logic generated.

Verification
REQ-033 Reset then bus1_sel_pc=1, inc_pc x3 -> bus_1 = 3; with PC=8'hFF, inc_pc -> PC=0.
REQ-034 R2=8'h0F (via mem_word), Y=8'hF1, IR opcode 1, load_z -> ALU=8'h00, zflag=1, cflag=1 (macro on) / 0 (off).
REQ-035 bus2_sel=10, load_ir=1, mem_valid=0 for 3 cycles then 1 with mem_word=8'h2A -> stall=1 for 3 cycles, IR=8'h2A one cycle after valid, PC unchanged with inc_pc held.
REQ-036 NUM_REGS=16, WORD_SIZE=16: write reg[15]=16'hBEEF, read same cycle -> old value 0, next cycle 16'hBEEF.
REQ-037 load_pc and inc_pc with Bus_2=8'h40 -> PC=8'h40; rst asserted mid-stall -> all registers 0 next edge.
